// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART command/response framer.
package uart_frame_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic       {IDLE, COLLECT}       rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, LOAD, WAIT} tx_state_t;

  // Counter width able to index n bytes; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart.sv
// Byte-wide 8N1 UART core, BAUD_DIV clks per bit. rx_rdy and tx_done are sticky flags.
module uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       clr_rx_rdy
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BIT_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF   = CW'(BAUD_DIV / 2);

  logic [9:0]    tx_sh;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [3:0]    tx_bits, rx_bits;
  logic          tx_act, rx_act;
  logic [1:0]    rx_sync;
  logic [8:0]    rx_sh;

  assign TX = tx_sh[0];

  // Transmit: start bit, 8 data bits LSB first, stop bit; line idles high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_sh <= '1; tx_cnt <= '0; tx_bits <= '0; tx_act <= 1'b0; tx_done <= 1'b0;
    end else if (trmt) begin
      tx_sh <= {1'b1, tx_data, 1'b0}; tx_cnt <= BIT_M1; tx_bits <= '0;
      tx_act <= 1'b1; tx_done <= 1'b0;
    end else if (tx_act) begin
      if (tx_cnt != '0) tx_cnt <= tx_cnt - CW'(1);
      else begin
        tx_cnt <= BIT_M1;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_bits == 4'd9) begin tx_act <= 1'b0; tx_done <= 1'b1; end
        else tx_bits <= tx_bits + 4'd1;
      end
    end

  // Receive: find the start edge, then sample mid-bit: start, 8 data, stop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_sync <= 2'b11; rx_sh <= '0; rx_cnt <= '0; rx_bits <= '0;
      rx_act <= 1'b0; rx_rdy <= 1'b0; rx_data <= '0;
    end else begin
      rx_sync <= {rx_sync[0], RX};
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_act) begin
        if (!rx_sync[1]) begin rx_act <= 1'b1; rx_cnt <= HALF; rx_bits <= '0; end
      end else if (rx_cnt != '0) rx_cnt <= rx_cnt - CW'(1);
      else begin
        rx_cnt <= BIT_M1;
        rx_sh  <= {rx_sync[1], rx_sh[8:1]};
        if (rx_bits == 4'd9) begin rx_act <= 1'b0; rx_rdy <= 1'b1; rx_data <= rx_sh[8:1]; end
        else rx_bits <= rx_bits + 4'd1;
      end
    end
endmodule

// File: rtl/uart_resp_seq.sv
// Response sequencer: latches a RESP_BYTES word and feeds it to the UART one byte at a time.
module uart_resp_seq import uart_frame_pkg::*; #(
  parameter int RESP_BYTES = 1,
  parameter bit MSB_FIRST  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trmt,
  input  logic [BYTE_W*RESP_BYTES-1:0] resp,
  input  logic                         u_tx_done,
  output logic                         u_trmt,
  output logic [BYTE_W-1:0]            u_tx_data,
  output logic                         tx_busy,
  output logic                         tx_done
);
  localparam int RW = BYTE_W * RESP_BYTES;
  localparam int BW = cnt_w(RESP_BYTES);

  tx_state_t      st, st_nxt;
  logic [RW-1:0]  sh;
  logic [BW-1:0]  cnt;
  logic           first, last;

  assign last      = (cnt == BW'(RESP_BYTES - 1));
  assign u_tx_data = MSB_FIRST ? sh[RW-1 -: BYTE_W] : sh[BYTE_W-1:0];
  assign tx_busy   = (st != TX_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= TX_IDLE;
    else        st <= st_nxt;

  // Next state and UART strobe; the UART's done flag is stale in the first WAIT clk
  always_comb begin
    st_nxt = st;
    u_trmt = 1'b0;
    case (st)
      TX_IDLE: if (trmt) st_nxt = LOAD;
      LOAD:    begin u_trmt = 1'b1; st_nxt = WAIT; end
      WAIT:    if (!first && u_tx_done) st_nxt = last ? TX_IDLE : LOAD;
      default: st_nxt = TX_IDLE;
    endcase
  end

  // Response shift register, byte counter and sticky done flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0; cnt <= '0; first <= 1'b0; tx_done <= 1'b0;
    end else begin
      case (st)
        TX_IDLE: if (trmt) begin sh <= resp; cnt <= '0; tx_done <= 1'b0; end
        LOAD:    begin first <= 1'b1; sh <= MSB_FIRST ? (sh << BYTE_W) : (sh >> BYTE_W); end
        WAIT:    begin
          first <= 1'b0;
          if (!first && u_tx_done) begin
            if (last) tx_done <= 1'b1;
            else      cnt <= cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
endmodule

// File: rtl/uart_cmd_framer.sv
// UART command/response framer: assembles CMD_BYTES into cmd, drops stale partial
// frames after an inter-byte timeout, and sends RESP_BYTES responses back to back.
module uart_cmd_framer import uart_frame_pkg::*; #(
  parameter int CMD_BYTES    = 2,
  parameter int RESP_BYTES   = 1,
  parameter bit MSB_FIRST    = 1,
  parameter int TIMEOUT_CLKS = 1250000,
  parameter int BAUD_DIV     = 434
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         RX,
  output logic                         TX,
  input  logic                         clr_cmd_rdy,
  output logic [BYTE_W*CMD_BYTES-1:0]  cmd,
  output logic                         cmd_rdy,
  output logic                         frame_err,
  input  logic                         trmt,
  input  logic [BYTE_W*RESP_BYTES-1:0] resp,
  output logic                         tx_busy,
  output logic                         tx_done
);
  localparam int CW = BYTE_W * CMD_BYTES;
  localparam int IW = cnt_w(CMD_BYTES);
  localparam int TW = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;

  rx_state_t         rx_st, rx_nxt;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tmo;
  logic [CW-1:0]     shadow, shadow_nxt;
  logic              rx_rdy, clr_rx_rdy, last_byte, commit, tmo_hit;
  logic [BYTE_W-1:0] rx_data, u_tx_data;
  logic              u_trmt, u_tx_done;
  int                slot;

  assign clr_rx_rdy = rx_rdy;
  assign last_byte  = (idx == IW'(CMD_BYTES - 1));

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .trmt(u_trmt), .tx_data(u_tx_data), .tx_done(u_tx_done),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy)
  );

  uart_resp_seq #(.RESP_BYTES(RESP_BYTES), .MSB_FIRST(MSB_FIRST)) u_seq (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .resp(resp),
    .u_tx_done(u_tx_done), .u_trmt(u_trmt), .u_tx_data(u_tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  // RX state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_st <= IDLE;
    else        rx_st <= rx_nxt;

  // RX next state: a byte opens or extends a frame, the last byte commits, silence aborts
  always_comb begin
    rx_nxt  = rx_st;
    commit  = 1'b0;
    tmo_hit = 1'b0;
    case (rx_st)
      IDLE:    if (rx_rdy) begin commit = last_byte; rx_nxt = last_byte ? IDLE : COLLECT; end
      COLLECT: if (rx_rdy) begin
                 commit = last_byte;
                 if (last_byte) rx_nxt = IDLE;
               end else if (TIMEOUT_CLKS != 0 && tmo == '0) begin
                 tmo_hit = 1'b1;
                 rx_nxt  = IDLE;
               end
      default: rx_nxt = IDLE;
    endcase
  end

  // Drop the incoming byte into its slot of the frame being built
  always_comb begin
    shadow_nxt = shadow;
    slot       = MSB_FIRST ? (CMD_BYTES - 1 - int'(idx)) : int'(idx);
    shadow_nxt[slot*BYTE_W +: BYTE_W] = rx_data;
  end

  // Byte index, shadow word, committed cmd, ready flag, error pulse and inter-byte timer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0; tmo <= '0; shadow <= '0; cmd <= '0; cmd_rdy <= 1'b0; frame_err <= 1'b0;
    end else begin
      frame_err <= tmo_hit;
      if (rx_rdy) begin
        shadow <= shadow_nxt;
        idx    <= last_byte ? '0 : idx + IW'(1);
        tmo    <= TW'(TIMEOUT_CLKS);
      end else begin
        if (tmo_hit) idx <= '0;
        if (rx_st == COLLECT && tmo != '0) tmo <= tmo - TW'(1);
      end
      // a commit outranks any clear in the same clk
      if (commit) begin cmd <= shadow_nxt; cmd_rdy <= 1'b1; end
      else if (clr_cmd_rdy || (rx_rdy && idx == '0)) cmd_rdy <= 1'b0;
    end
endmodule

// File: tb/tb_uart_cmd_framer.sv
// Scoreboard bench for uart_cmd_framer: two instances (3-byte MSB-first with timeout,
// 2-byte LSB-first without). Stimulus pushes expected words/bytes; monitors pop and compare.
module tb_uart_cmd_framer;
  localparam int BD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rx_l = 2'b11, clr_l = 2'b00, trmt_l = 2'b00;
  logic [15:0] resp_a = '0;
  logic [7:0]  resp_b = '0;
  logic [1:0]  tx_l, cmd_rdy_l, ferr_l, busy_l, done_l;
  logic [23:0] cmd_a;
  logic [15:0] cmd_b;

  int n_chk = 0, n_fail = 0;
  logic [63:0] q_cmd_a[$], q_cmd_b[$];
  logic [7:0]  q_tx_a[$], q_tx_b[$];
  int ferr_cnt[2] = '{0, 0};
  int exp_ferr[2] = '{0, 0};
  bit tx_chk_en[2] = '{1'b1, 1'b1};

  always #5 clk = ~clk;

  uart_cmd_framer #(.CMD_BYTES(3), .RESP_BYTES(2), .MSB_FIRST(1), .TIMEOUT_CLKS(1000), .BAUD_DIV(BD)) dut_a (
    .clk(clk), .rst_n(rst_n), .RX(rx_l[0]), .TX(tx_l[0]), .clr_cmd_rdy(clr_l[0]),
    .cmd(cmd_a), .cmd_rdy(cmd_rdy_l[0]), .frame_err(ferr_l[0]), .trmt(trmt_l[0]),
    .resp(resp_a), .tx_busy(busy_l[0]), .tx_done(done_l[0]));

  uart_cmd_framer #(.CMD_BYTES(2), .RESP_BYTES(1), .MSB_FIRST(0), .TIMEOUT_CLKS(0), .BAUD_DIV(BD)) dut_b (
    .clk(clk), .rst_n(rst_n), .RX(rx_l[1]), .TX(tx_l[1]), .clr_cmd_rdy(clr_l[1]),
    .cmd(cmd_b), .cmd_rdy(cmd_rdy_l[1]), .frame_err(ferr_l[1]), .trmt(trmt_l[1]),
    .resp(resp_b), .tx_busy(busy_l[1]), .tx_done(done_l[1]));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_cmd_a"}, 64'(cmd_a), 0);
    chk({tag, "_cmd_b"}, 64'(cmd_b), 0);
    chk({tag, "_cmd_rdy"}, 64'(cmd_rdy_l), 0);
    chk({tag, "_frame_err"}, 64'(ferr_l), 0);
    chk({tag, "_tx_busy"}, 64'(busy_l), 0);
    chk({tag, "_tx_done"}, 64'(done_l), 0);
    chk({tag, "_tx_idle"}, 64'(tx_l), 3);
  endtask

  // Serial byte onto RX of instance w, followed by a short idle
  task automatic send_byte(int w, logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx_l[w] = f[i];
      repeat (BD - 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  // Reference: MSB-first instance puts the first byte on top, LSB-first at the bottom
  function automatic logic [63:0] frame_val(int w, logic [7:0] bs[3]);
    logic [63:0] e;
    e = 0;
    if (w == 0) for (int i = 0; i < 3; i++) e = (e << 8) | 64'(bs[i]);
    else        for (int i = 0; i < 2; i++) e = e + (64'(bs[i]) << (8 * i));
    return e;
  endfunction

  task automatic push_cmd(int w, logic [63:0] e);
    if (w == 0) q_cmd_a.push_back(e); else q_cmd_b.push_back(e);
  endtask

  task automatic send_frame(int w, logic [7:0] bs[3], bit do_clr);
    push_cmd(w, frame_val(w, bs));
    for (int i = 0; i < (w == 0 ? 3 : 2); i++) begin
      send_byte(w, bs[i]);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    if (do_clr) begin
      chk($sformatf("cmd_rdy%0d_set", w), 64'(cmd_rdy_l[w]), 1);
      clr_l[w] = 1'b1; @(negedge clk); clr_l[w] = 1'b0;
      chk($sformatf("cmd_rdy%0d_clr", w), 64'(cmd_rdy_l[w]), 0);
    end
  endtask

  task automatic send_resp(int w, logic [15:0] r, bit mid_trmt);
    int gaps, cyc;
    @(negedge clk);
    if (w == 0) begin resp_a = r; q_tx_a.push_back(r[15:8]); q_tx_a.push_back(r[7:0]); end
    else begin resp_b = r[7:0]; q_tx_b.push_back(r[7:0]); end
    trmt_l[w] = 1'b1; @(negedge clk); trmt_l[w] = 1'b0;
    resp_a = 16'(~r); resp_b = 8'(~r);   // must not matter after acceptance
    chk($sformatf("tx%0d_busy_start", w), 64'(busy_l[w]), 1);
    chk($sformatf("tx%0d_done_clr", w), 64'(done_l[w]), 0);
    gaps = 0; cyc = 0;
    while (!done_l[w] && cyc < 400) begin
      if (!busy_l[w]) gaps++;
      if (mid_trmt && cyc == 30) begin
        resp_a = 16'h0BAD; resp_b = 8'hAD; trmt_l[w] = 1'b1;
        @(negedge clk); trmt_l[w] = 1'b0; cyc++;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    chk($sformatf("tx%0d_done", w), 64'(done_l[w]), 1);
    chk($sformatf("tx%0d_busy_end", w), 64'(busy_l[w]), 0);
    chk($sformatf("tx%0d_busy_gap", w), 64'(gaps), 0);
    repeat (2 * BD) @(negedge clk);
  endtask

  // Monitor: each rising cmd_rdy must present the next expected frame; cmd holds otherwise
  task automatic cmd_mon(int w);
    logic prev;
    logic [63:0] last, cur, e;
    prev = 1'b0; last = 0;
    forever begin
      @(negedge clk);
      cur = (w == 0) ? 64'(cmd_a) : 64'(cmd_b);
      if (!rst_n) begin prev = 1'b0; last = 0; continue; end
      if (cmd_rdy_l[w] && !prev) begin
        if ((w == 0 ? q_cmd_a.size() : q_cmd_b.size()) == 0) begin
          n_chk++; n_fail++;
          $display("FAIL cmd%0d_unexpected: got %0h expected no frame", w, cur);
        end else begin
          e = (w == 0) ? q_cmd_a.pop_front() : q_cmd_b.pop_front();
          chk($sformatf("cmd%0d_frame", w), cur, e);
        end
      end else chk($sformatf("cmd%0d_hold", w), cur, last);
      last = cur; prev = cmd_rdy_l[w];
    end
  endtask

  // Monitor: frame_err is a single-clk pulse; count pulses
  task automatic ferr_mon(int w);
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev = 1'b0; continue; end
      if (ferr_l[w]) begin
        if (prev) begin
          n_chk++; n_fail++;
          $display("FAIL ferr%0d_width: got pulse wider than 1 clk expected 1 clk", w);
        end else ferr_cnt[w]++;
      end
      prev = ferr_l[w];
    end
  endtask

  // Monitor: decode the TX line and compare each byte with the expected queue
  task automatic tx_mon(int w);
    logic [7:0] b, e;
    logic stop;
    forever begin
      @(negedge clk);
      if (rst_n && !tx_l[w]) begin
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin repeat (BD) @(negedge clk); b[i] = tx_l[w]; end
        repeat (BD) @(negedge clk);
        stop = tx_l[w];
        if (tx_chk_en[w]) begin
          if ((w == 0 ? q_tx_a.size() : q_tx_b.size()) == 0) begin
            n_chk++; n_fail++;
            $display("FAIL tx%0d_unexpected: got %0h expected no byte", w, b);
          end else begin
            e = (w == 0) ? q_tx_a.pop_front() : q_tx_b.pop_front();
            chk($sformatf("tx%0d_byte", w), 64'(b), 64'(e));
            chk($sformatf("tx%0d_stop", w), 64'(stop), 1);
          end
        end
      end
    end
  endtask

  initial cmd_mon(0);
  initial cmd_mon(1);
  initial ferr_mon(0);
  initial ferr_mon(1);
  initial tx_mon(0);
  initial tx_mon(1);

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] bs[3];
    int k;
    repeat (5) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frames on both instances
    bs = '{8'hA5, 8'h3C, 8'h0F}; send_frame(0, bs, 1);
    bs = '{8'h34, 8'h12, 8'h00}; send_frame(1, bs, 0);
    // Next frame's first byte drops cmd_rdy; cmd keeps the old word
    push_cmd(1, 64'h7856);
    send_byte(1, 8'h56);
    chk("b_rdy_drop", 64'(cmd_rdy_l[1]), 0);
    chk("b_cmd_keep", 64'(cmd_b), 64'h1234);
    send_byte(1, 8'h78);

    // Timeout on A: a gap just under the limit is fine, a longer one drops the frame
    bs = '{8'h11, 8'h22, 8'h33}; push_cmd(0, frame_val(0, bs));
    send_byte(0, bs[0]); repeat (900) @(negedge clk);
    send_byte(0, bs[1]); repeat (900) @(negedge clk);
    send_byte(0, bs[2]);
    chk("a_no_timeout", 64'(ferr_cnt[0]), 0);
    send_byte(0, 8'h99); repeat (1100) @(negedge clk);
    exp_ferr[0]++;
    chk("a_timeout_err", 64'(ferr_cnt[0]), 64'(exp_ferr[0]));
    chk("a_timeout_cmd", 64'(cmd_a), 64'h112233);
    bs = '{8'hBE, 8'hEF, 8'h01}; send_frame(0, bs, 1);
    // B has the timeout disabled: a long gap still completes the frame
    bs = '{8'h5A, 8'hC3, 8'h00}; push_cmd(1, frame_val(1, bs));
    send_byte(1, bs[0]); repeat (1500) @(negedge clk);
    chk("b_no_timeout", 64'(ferr_cnt[1]), 0);
    send_byte(1, bs[1]);
    clr_l[1] = 1'b1; @(negedge clk); clr_l[1] = 1'b0;

    // Responses, with an ignored trmt mid-send
    send_resp(0, 16'hCAFE, 1);
    send_resp(1, 16'h00A7, 1);

    // Full duplex, with clr_cmd_rdy landing on the final byte's clk
    bs = '{8'hD0, 8'h0D, 8'h42};
    fork
      send_frame(0, bs, 0);
      send_resp(0, 16'h1357, 0);
      begin
        k = 0;
        while (!(dut_a.rx_rdy && dut_a.idx == 2) && k < 2000) begin @(negedge clk); k++; end
        chk("dup_final_byte_seen", 64'(k < 2000), 1);
        clr_l[0] = 1'b1; @(negedge clk); clr_l[0] = 1'b0;
        chk("dup_set_wins", 64'(cmd_rdy_l[0]), 1);
      end
    join
    clr_l[0] = 1'b1; @(negedge clk); clr_l[0] = 1'b0;

    // Randomised traffic
    for (int it = 0; it < 16; it++) begin
      int w;
      w = int'($urandom_range(0, 1));
      foreach (bs[i]) bs[i] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) send_resp(w, 16'($urandom), 1'($urandom_range(0, 1)));
      else send_frame(w, bs, 1'($urandom_range(0, 1)));
    end

    // Reset mid-frame and mid-response
    send_byte(0, 8'h77);
    tx_chk_en[0] = 1'b0;
    @(negedge clk); resp_a = 16'h2468; trmt_l[0] = 1'b1; @(negedge clk); trmt_l[0] = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("midrst");
    q_tx_a.delete();
    rst_n = 1'b1;
    repeat (12 * BD) @(negedge clk);
    chk_reset("postrst");
    tx_chk_en[0] = 1'b1;
    bs = '{8'hF1, 8'hE2, 8'hD3}; send_frame(0, bs, 1);
    send_resp(0, 16'h55AA, 0);

    // Drain
    k = 0;
    while ((q_cmd_a.size() + q_cmd_b.size() + q_tx_a.size() + q_tx_b.size()) != 0 && k < 500) begin
      @(negedge clk); k++;
    end
    chk("q_cmd_a_empty", 64'(q_cmd_a.size()), 0);
    chk("q_cmd_b_empty", 64'(q_cmd_b.size()), 0);
    chk("q_tx_a_empty", 64'(q_tx_a.size()), 0);
    chk("q_tx_b_empty", 64'(q_tx_b.size()), 0);
    chk("ferr_a_total", 64'(ferr_cnt[0]), 64'(exp_ferr[0]));
    chk("ferr_b_total", 64'(ferr_cnt[1]), 64'(exp_ferr[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
